flot_square_iter: RTL and testbench

- Iterative floating-point squarer; the inverse operation of the square-root path.
- Accepts one packed float operand, squares its mantissa with a one-bit-per-cycle shift-add multiplier, doubles and re-biases the exponent, normalizes and optionally rounds.
- Returns a packed float with an exception flag.
- Sits beside the square-root unit in the ALU, behind a valid/ready handshake so the ALU can stall on it.

---
 rtl/flot_pkg.sv | 23 ++
 rtl/mant_shift_add_mul.sv | 51 +++++
 rtl/flot_square_iter.sv | 128 ++++++++++++
 tb/tb_flot_square_iter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/flot_pkg.sv
// Shared floating-point definitions for the squarer and the square-root path:
// format widths, exponent bias, special exponents and the iterative-unit FSM states.
package flot_pkg;

  localparam int FLOT_WIDTH     = 32;
  localparam int FLOT_WIDTH_EXP = 8;
  localparam int FLOT_WIDTH_MAT = 23;

  localparam logic [FLOT_WIDTH_EXP-1:0] EXP_ONES = '1;
  localparam logic [FLOT_WIDTH_EXP-1:0] EXP_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int bias(input int width_exp);
    return (1 << (width_exp - 1)) - 1;
  endfunction

endpackage

// File: rtl/mant_shift_add_mul.sv
// Iterative N x N unsigned shift-add multiplier, one multiplier bit per enabled cycle.
// start loads the operands; done is high during the cycle of the last addition.
module mant_shift_add_mul #(
  parameter int N = 24
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CE,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  count;
  logic           busy;

  assign done = busy && (count == LAST);

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      busy    <= 1'b0;
      product <= '0;
    end else if (CE) begin
      if (start) begin
        mcand   <= {{N{1'b0}}, a};
        mplier  <= b;
        count   <= '0;
        busy    <= 1'b1;
        product <= '0;
      end else if (busy) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (done) busy <= 1'b0;
        else      count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/flot_square_iter.sv
// Iterative floating-point squarer behind a valid/ready handshake.
// Define FLOT_SQUARE_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module flot_square_iter
  import flot_pkg::*;
#(
  parameter int WIDTH     = FLOT_WIDTH,
  parameter int WIDTH_exp = FLOT_WIDTH_EXP,
  parameter int WIDTH_mat = FLOT_WIDTH_MAT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] OP,
  input  logic             exce_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             exce_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int M  = WIDTH_mat;
  localparam int EW = WIDTH_exp + 2;
  localparam logic signed [EW-1:0] BIAS   = EW'(bias(WIDTH_exp));
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << WIDTH_exp) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  state_t state, state_next;

  logic [WIDTH_exp-1:0] exp_q;
  logic [M-1:0]         man_q;
  logic                 exce_q;
  logic                 start, mul_done;
  logic [M:0]           mant_in;
  logic [2*M+1:0]       prod, prod_n;

  logic                 norm, carry;
  logic [M-1:0]         mant_t, mant_r;
  logic signed [EW-1:0] e_raw, e_fin;
  logic [WIDTH-1:0]     res_next;
  logic                 exce_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign start     = in_ready && in_valid;
  assign mant_in   = {1'b1, OP[M-1:0]};

  mant_shift_add_mul #(.N(M + 1)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .start   (start),
    .a       (mant_in),
    .b       (mant_in),
    .done    (mul_done),
    .product (prod)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = MUL;
      MUL:     if (mul_done)  state_next = NORM;
      NORM:                   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    norm   = prod[2*M+1];
    prod_n = norm ? prod : prod << 1;
    mant_t = prod_n[2*M:M+1];
    // 2*exp + norm is just the exponent with norm appended as its LSB.
    e_raw  = $signed({1'b0, exp_q, norm}) - BIAS;
`ifdef FLOT_SQUARE_ROUND_EN
    {carry, mant_r} = {1'b0, mant_t}
                    + (M + 1)'(prod_n[M] && ((|prod_n[M-1:0]) || mant_t[0]));
`else
    carry  = 1'b0;
    mant_r = mant_t;
`endif
    e_fin  = e_raw + $signed(EW'(carry));

    res_next  = '0;
    exce_next = exce_q;
    if (&exp_q) begin
      res_next  = {1'b0, exp_q, man_q};
      exce_next = 1'b1;
    end else if (exp_q == '0) begin
      res_next  = '0;
      exce_next = exce_q;
    end else if (e_fin >= E_MAX) begin
      res_next  = {1'b0, {WIDTH_exp{1'b1}}, {M{1'b0}}};
      exce_next = 1'b1;
    end else if (e_fin <= E_ZERO) begin
      res_next  = '0;
      exce_next = 1'b1;
    end else begin
      res_next  = {1'b0, e_fin[WIDTH_exp-1:0], mant_r};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      exp_q    <= '0;
      man_q    <= '0;
      exce_q   <= 1'b0;
      result   <= '0;
      exce_out <= 1'b0;
    end else if (CE) begin
      state <= state_next;
      if (start) begin
        exp_q  <= OP[WIDTH-2 -: WIDTH_exp];
        man_q  <= OP[M-1:0];
        exce_q <= exce_in;
      end
      if (state == NORM) begin
        result   <= res_next;
        exce_out <= exce_next;
      end
    end
  end

endmodule

// File: tb/tb_flot_square_iter.sv
// Scoreboard bench for flot_square_iter: directed operands push expected results,
// a monitor pops and compares on every output handshake.
module tb_flot_square_iter;

  logic        CLK = 1'b0;
  logic        RST, CE, exce_in, in_valid, out_ready;
  logic [31:0] OP;
  logic        in_ready, exce_out, out_valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        exce;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_miss   = 0;

  flot_square_iter dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .OP        (OP),
    .exce_in   (exce_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .exce_out  (exce_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  // Monitor: one pop per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (out_valid && out_ready && CE) begin
        if (sb.size() == 0) begin
          check("unexpected output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, " result"}, result, e.res);
          check({e.name, " exce_out"}, 32'(exce_out), 32'(e.exce));
        end
      end
    end
  end

  // Issue one operand; lat counts clock edges from the accepting edge (=1) to out_valid.
  task automatic issue(input logic [31:0] op, input logic ex, input bit noise,
                       input bit stall, output int lat);
    @(posedge CLK);
    #1;
    check("in_ready before issue", 32'(in_ready), 32'd1);
    OP       = op;
    exce_in  = ex;
    in_valid = 1'b1;
    @(posedge CLK);
    lat = 1;
    #1 in_valid = 1'b0;
    while (lat < 200) begin
      @(negedge CLK);
      if (out_valid) break;
      @(posedge CLK);
      lat++;
      #1;
      CE       = !(stall && lat >= 8 && lat < 13);
      in_valid = noise && (lat == 4 || lat == 12);
      if (in_valid) OP = 32'h5F80_0000;
    end
    in_valid = 1'b0;
    CE       = 1'b1;
  endtask

  task automatic run(input logic [31:0] op, input logic ex, input logic [31:0] res,
                     input logic rex, input string name, input int want_lat,
                     input bit noise, input bit stall);
    exp_t e;
    int   lat;
    e.res  = res;
    e.exce = rex;
    e.name = name;
    sb.push_back(e);
    issue(op, ex, noise, stall, lat);
    check({name, " latency"}, 32'(lat), 32'(want_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [31:0] rnd_exp;
`ifdef FLOT_SQUARE_ROUND_EN
    rnd_exp = 32'h3F80_1003;
`else
    rnd_exp = 32'h3F80_1002;
`endif
    RST = 1'b1; CE = 1'b1; OP = '0; exce_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result",    result,         32'd0);
    check("reset exce_out",  32'(exce_out),  32'd0);

    run(32'h4040_0000, 1'b0, 32'h4110_0000, 1'b0, "3.0",       26, 1'b0, 1'b0);
    run(32'hC000_0000, 1'b0, 32'h4080_0000, 1'b0, "-2.0",      26, 1'b0, 1'b0);
    run(32'h3F80_0801, 1'b0, rnd_exp,       1'b0, "round",     26, 1'b0, 1'b0);
    run(32'h5F80_0000, 1'b0, 32'h7F80_0000, 1'b1, "overflow",  26, 1'b0, 1'b0);
    run(32'h1F80_0000, 1'b0, 32'h0000_0000, 1'b1, "underflow", 26, 1'b0, 1'b0);
    run(32'h0040_0000, 1'b0, 32'h0000_0000, 1'b0, "denormal",  26, 1'b0, 1'b0);
    run(32'h7FC0_0000, 1'b0, 32'h7FC0_0000, 1'b1, "nan",       26, 1'b0, 1'b0);
    run(32'h4040_0000, 1'b1, 32'h4110_0000, 1'b1, "3.0 exce",  26, 1'b0, 1'b0);
    run(32'h3FC0_0000, 1'b0, 32'h4010_0000, 1'b0, "1.5 noise", 26, 1'b1, 1'b0);
    run(32'h4040_0000, 1'b0, 32'h4110_0000, 1'b0, "3.0 stall", 31, 1'b0, 1'b1);

    // Backpressure: hold out_ready low for 10 cycles while in_valid is pushed.
    @(posedge CLK);
    #1 out_ready = 1'b0;
    run(32'h4000_0000, 1'b0, 32'h4080_0000, 1'b0, "2.0 bp", 26, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      in_valid = 1'b1;
      OP       = 32'h5F80_0000;
      @(negedge CLK);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp result",    result,         32'h4080_0000);
      check("bp exce_out",  32'(exce_out),  32'd0);
      check("bp in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge CLK);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("bp release in_ready",  32'(in_ready),  32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);

    // Reset in MUL cycle 10: operand discarded, no output.
    @(posedge CLK);
    #1;
    OP = 32'h4040_0000; exce_in = 1'b0; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst mid in_ready",  32'(in_ready),  32'd1);
    check("rst mid out_valid", 32'(out_valid), 32'd0);
    check("rst mid result",    result,         32'd0);
    check("rst mid exce_out",  32'(exce_out),  32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    check("rst no out_valid", 32'(seen), 32'd0);
    run(32'h4040_0000, 1'b0, 32'h4110_0000, 1'b0, "3.0 after rst", 26, 1'b0, 1'b0);

    repeat (5) @(posedge CLK);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
